fp_mantissa_seq_multiplier: RTL
===============================

Name: fp_mantissa_seq_multiplier

Overview:
- Iterative shift-and-add stage directly upstream of the FP multiplier's normalizer.
- Takes two IEEE-style operands as exponent/fraction pairs and forms the raw 2*(MANTISSA_WIDTH+1)-bit mantissa product over MANTISSA_WIDTH+1 cycles.
- Also produces the biased exponent sum plus overflow/underflow flags.
- Outputs map one-to-one onto the normalizer's expoent_in, result_in and carry_in.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 23, fraction field width; N = MANTISSA_WIDTH+1 is the significand width.
- BIAS, 2**(EXP_WIDTH-1)-1, exponent bias subtracted from the sum.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- start_in  input  1  operand-valid strobe; accepted only while ready_out=1.
- expoent_a_in  input  EXP_WIDTH  operand A biased exponent.
- mantissa_a_in  input  MANTISSA_WIDTH  operand A fraction, hidden bit excluded.
- expoent_b_in  input  EXP_WIDTH  operand B biased exponent.
- mantissa_b_in  input  MANTISSA_WIDTH  operand B fraction.
- ready_out  output  1  block can accept start_in.
- valid_out  output  1  result fields valid.
- result_out  output  2*N  raw significand product; feeds normalizer result_in.
- expoent_out  output  EXP_WIDTH  low EXP_WIDTH bits of expA+expB-BIAS.
- carry_out  output  1  exponent sum >= 2**EXP_WIDTH; feeds normalizer carry_in.
- underflow_out  output  1  exponent sum < 0.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_n_in=0 at an edge) forces IDLE from any state, including mid-BUSY. It clears the accumulator, counter and all outputs to 0, except ready_out=1.
- ready_out=1 in IDLE and DONE; 0 in BUSY.
- start_in during BUSY is ignored. Operands are not sampled and the current operation is unaffected.
- Accept (start_in=1 and ready_out=1):
  - Significands: sigA = {expA!=0, mantissa_a_in}; sigB likewise. A zero exponent gives hidden bit 0.
  - Multiplicand register (2*N bits) <= zero-extended sigA.
  - Multiplier shift register (N bits) <= sigB.
  - Accumulator <= 0; counter <= 0.
  - Exponent: computed once in EXP_WIDTH+2-bit signed arithmetic, S = expA + expB - BIAS. Registered as expoent_out = S[EXP_WIDTH-1:0], carry_out = (S >= 2**EXP_WIDTH), underflow_out = (S < 0).
  - valid_out <= 0. Next state BUSY.
- BUSY, each cycle:
  - If multiplier[0] then accumulator += multiplicand. The 2*N width never overflows.
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - When counter reaches N-1 (the Nth BUSY cycle), go to DONE.
- DONE: result_out = accumulator; valid_out=1. Outputs hold until the next accepted start or reset.
- Back-to-back: a start accepted in DONE drops valid_out on the next edge and restarts BUSY.
- Latency: valid_out rises exactly N+1 edges after the accepting edge (1 load + N BUSY). Throughput is one result per N+1 cycles.
- Counter width: clog2(N+1) bits; it never wraps.
- result_out, expoent_out, carry_out and underflow_out are registered and stable whenever valid_out=1.
- result_out is in the normalizer's input format: bit 2N-1 set means the product is in [2,4); otherwise bit 2N-2 holds the leading 1 for normal operands.

Optional Feature:
- Macro: FP_MUL_ZERO_BYPASS_EN.
- Defined: on accept, if either operand is exactly zero (exponent=0 and fraction=0), skip BUSY and go straight to DONE.
  - result_out=0, expoent_out=0, carry_out=0, underflow_out=0.
  - valid_out rises 1 edge after accept.
- Undefined: zero operands take the full N+1-cycle path. result_out=0 naturally; exponent flags are computed as normal.

Test Plan:
- 1.0*1.0 (E=8, M=23): expA=expB=127, fractions 0, start pulse -> after 25 edges valid_out=1, result_out=48'h4000_0000_0000, expoent_out=127, carry_out=0, underflow_out=0.
- 1.5*1.5 with expA=expB=200: fractions 0x400000 -> result_out=48'h9000_0000_0000, expoent_out=17 (273-256), carry_out=1, underflow_out=0.
- expA=expB=10, fractions 0 -> underflow_out=1, carry_out=0, result_out=48'h4000_0000_0000.
- Zero operand: A=0/0, B=1.0 -> result_out=0. valid_out at edge 25 without macro, at edge 1 with FP_MUL_ZERO_BYPASS_EN.
- start_in held high with new operands during BUSY -> ignored, first result unchanged. Start in DONE -> valid_out drops next edge and the second result appears 25 edges later.
- rst_n_in=0 at BUSY cycle 10 -> next edge IDLE, ready_out=1, valid_out=0, all outputs 0. A fresh start then completes correctly.

Source files
------------

// File: rtl/fp_mantissa_seq_multiplier.sv
// Iterative shift-and-add significand multiplier feeding the FP normalizer.
// Optional FP_MUL_ZERO_BYPASS_EN: exact-zero operands skip the BUSY iterations.
//
// state | meaning
// IDLE  | waiting for start_in after reset
// BUSY  | one shift-and-add step per cycle, N cycles
// DONE  | result held with valid_out=1; may accept a new start
module fp_mantissa_seq_multiplier #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int BIAS           = 2**(EXP_WIDTH-1)-1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    input  logic [EXP_WIDTH-1:0]          expoent_a_in,
    input  logic [MANTISSA_WIDTH-1:0]     mantissa_a_in,
    input  logic [EXP_WIDTH-1:0]          expoent_b_in,
    input  logic [MANTISSA_WIDTH-1:0]     mantissa_b_in,
    output logic                          ready_out,
    output logic                          valid_out,
    output logic [2*(MANTISSA_WIDTH+1)-1:0] result_out,
    output logic [EXP_WIDTH-1:0]          expoent_out,
    output logic                          carry_out,
    output logic                          underflow_out
);

    localparam int N  = MANTISSA_WIDTH + 1;
    localparam int PW = 2 * N;
    localparam int CW = $clog2(N + 1);
    localparam int SW = EXP_WIDTH + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        mcand_q, mcand_d;
    logic [N-1:0]         mplier_q, mplier_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic                 carry_q, carry_d;
    logic                 uf_q, uf_d;
    logic                 valid_q, valid_d;

    logic [N-1:0]          sig_a, sig_b;
    logic signed [SW-1:0]  exp_sum;

    // Denormal operands (exponent 0) carry a zero hidden bit.
    assign sig_a   = {(expoent_a_in != '0), mantissa_a_in};
    assign sig_b   = {(expoent_b_in != '0), mantissa_b_in};
    assign exp_sum = $signed({2'b00, expoent_a_in}) + $signed({2'b00, expoent_b_in})
                     - $signed(SW'(BIAS));

`ifdef FP_MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = ((expoent_a_in == '0) && (mantissa_a_in == '0)) ||
                     ((expoent_b_in == '0) && (mantissa_b_in == '0));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        carry_d  = carry_q;
        uf_d     = uf_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    mcand_d  = {{N{1'b0}}, sig_a};
                    mplier_d = sig_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    exp_d    = exp_sum[EXP_WIDTH-1:0];
                    carry_d  = ~exp_sum[SW-1] & exp_sum[SW-2];
                    uf_d     = exp_sum[SW-1];
                    valid_d  = 1'b0;
                    state_d  = BUSY;
`ifdef FP_MUL_ZERO_BYPASS_EN
                    if (zero_op) begin
                        exp_d   = '0;
                        carry_d = 1'b0;
                        uf_d    = 1'b0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            carry_q  <= 1'b0;
            uf_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            carry_q  <= carry_d;
            uf_q     <= uf_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_out     = (state_q != BUSY);
    assign valid_out     = valid_q;
    assign result_out    = acc_q;
    assign expoent_out   = exp_q;
    assign carry_out     = carry_q;
    assign underflow_out = uf_q;

endmodule
